// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_event_t;

  localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_rx_state_t;

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser plus run-length filter for one raw PS/2 line.
// The output powers up and resets to 1, which is the idle level of the bus.
module ps2_line_filter #(
  parameter int unsigned FILTER_LEN = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic filt
);

  logic       sync1_q;
  logic       sync2_q;
  logic       level_q;
  logic [7:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == 8'(FILTER_LEN - 1)) begin
        // FILTER_LEN-th consecutive disagreeing sample: accept the new level
        level_q <= sync2_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 8'd1;
      end
    end
  end

  assign filt = level_q;

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: filtered line sampling, 11-bit frame deserialiser with
// watchdog, E0/F0 prefix folding and a first-word-fall-through event FIFO.
module ps2_kbd_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN  = 16,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic                          CLOCK_50,
  input  logic                          reset_n,
  input  logic                          PS2_CLK,
  input  logic                          PS2_DAT,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [7:0]                    ev_code,
  output logic                          ev_ext,
  output logic                          ev_brk,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          err_parity,
  output logic                          err_frame,
  output logic                          overflow
);

  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = AW + 1;
  localparam int unsigned WDW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0]  FULL_CNT = CW'(FIFO_DEPTH);

  logic clk_f;
  logic dat_f;

  ps2_line_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_clk_filter (
    .clk   (CLOCK_50),
    .rst_n (reset_n),
    .raw   (PS2_CLK),
    .filt  (clk_f)
  );

  ps2_line_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_dat_filter (
    .clk   (CLOCK_50),
    .rst_n (reset_n),
    .raw   (PS2_DAT),
    .filt  (dat_f)
  );

  // Frame deserialiser
  ps2_rx_state_t  state_q, state_d;
  logic [2:0]     bitcnt_q, bitcnt_d;
  logic [7:0]     shreg_q, shreg_d;
  logic           ok_q, ok_d;
  logic [WDW-1:0] wd_q, wd_d;
  logic           clk_prev_q;
  logic           fall;
  logic           byte_done_q, byte_done_d;
  logic           perr_q, perr_d;
  logic           ferr_q, ferr_d;

  assign fall = clk_prev_q & ~clk_f;

  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    shreg_d     = shreg_q;
    ok_d        = ok_q;
    byte_done_d = 1'b0;
    perr_d      = 1'b0;
    ferr_d      = 1'b0;
    wd_d        = wd_q + 1'b1;
    if (state_q == IDLE || fall) begin
      wd_d = '0;
    end
    if (fall) begin
      unique case (state_q)
        IDLE: begin
          if (!dat_f) begin
            state_d  = DATA;
            bitcnt_d = 3'd0;
          end else begin
            ferr_d = 1'b1;
          end
        end
        DATA: begin
          shreg_d  = {dat_f, shreg_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) begin
            state_d = PARITY;
          end
        end
        PARITY: begin
          ok_d    = (^shreg_q) ^ dat_f;
          state_d = STOP;
        end
        STOP: begin
          // A bad stop bit is reported as a framing error even if parity also failed
          if (!dat_f) begin
            ferr_d = 1'b1;
          end else if (ok_q) begin
            byte_done_d = 1'b1;
          end else begin
            perr_d = 1'b1;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && wd_q == WD_LAST) begin
      state_d = IDLE;
      ferr_d  = 1'b1;
      wd_d    = '0;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      bitcnt_q    <= '0;
      shreg_q     <= '0;
      ok_q        <= 1'b0;
      wd_q        <= '0;
      clk_prev_q  <= 1'b1;
      byte_done_q <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shreg_q     <= shreg_d;
      ok_q        <= ok_d;
      wd_q        <= wd_d;
      clk_prev_q  <= clk_f;
      byte_done_q <= byte_done_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
    end
  end

  assign err_parity = perr_q;
  assign err_frame  = ferr_q;

  // Prefix decoder; shreg_q still holds the completed byte one cycle after byte_done
  logic       ext_q, ext_d;
  logic       brk_q, brk_d;
  logic       push;
  ps2_event_t push_ev;

  always_comb begin
    ext_d   = ext_q;
    brk_d   = brk_q;
    push    = 1'b0;
    push_ev = '{ext: ext_q, brk: brk_q, code: shreg_q};
    if (perr_q || ferr_q) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (byte_done_q) begin
      if (shreg_q == PS2_PFX_EXT) begin
        ext_d = 1'b1;
      end else if (shreg_q == PS2_PFX_BRK) begin
        brk_d = 1'b1;
      end else begin
        push  = 1'b1;
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
  end

  // Event FIFO
  ps2_event_t        mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wptr_q, rptr_q;
  logic [CW-1:0]     count_q, count_d;
  logic              ovf_q;
  logic              full;
  logic              pop;
  logic              do_push;

  assign full    = (count_q == FULL_CNT);
  assign pop     = (count_q != '0) && ev_ready;
  assign do_push = push && (!full || pop);

  always_comb begin
    count_d = count_q;
    unique case ({do_push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      ext_q   <= 1'b0;
      brk_q   <= 1'b0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= push_ev;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      count_q <= count_d;
      ovf_q   <= push && full && !pop;
      ext_q   <= ext_d;
      brk_q   <= brk_d;
    end
  end

  assign ev_valid   = (count_q != '0);
  assign fifo_count = count_q;
  assign ev_code    = mem_q[rptr_q].code;
  assign ev_ext     = mem_q[rptr_q].ext;
  assign ev_brk     = mem_q[rptr_q].brk;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed bench for ps2_kbd_rx: frames, prefixes, errors, timeout, overflow, glitch, reset.
module tb_ps2_kbd_rx;

  localparam int unsigned FILTER_LEN  = 4;
  localparam int unsigned FIFO_DEPTH  = 8;
  localparam int unsigned TIMEOUT_CYC = 200;

  logic       CLOCK_50 = 1'b0;
  logic       reset_n  = 1'b0;
  logic       PS2_CLK  = 1'b1;
  logic       PS2_DAT  = 1'b1;
  logic       ev_valid;
  logic       ev_ready = 1'b0;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_brk;
  logic [3:0] fifo_count;
  logic       err_parity;
  logic       err_frame;
  logic       overflow;

  int total = 0;
  int bad   = 0;
  int n_par = 0;
  int n_frm = 0;
  int n_ovf = 0;
  logic [9:0] evq[$];

  ps2_kbd_rx #(
    .FILTER_LEN  (FILTER_LEN),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .reset_n    (reset_n),
    .PS2_CLK    (PS2_CLK),
    .PS2_DAT    (PS2_DAT),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_code    (ev_code),
    .ev_ext     (ev_ext),
    .ev_brk     (ev_brk),
    .fifo_count (fifo_count),
    .err_parity (err_parity),
    .err_frame  (err_frame),
    .overflow   (overflow)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  // Observe away from the active edge; a handshake seen here pops at the next posedge
  always @(negedge CLOCK_50) begin
    if (ev_valid && ev_ready) evq.push_back({ev_ext, ev_brk, ev_code});
    if (err_parity) n_par++;
    if (err_frame) n_frm++;
    if (overflow) n_ovf++;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      PS2_DAT = bits[i];
      cyc(10);
      PS2_CLK = 1'b0;
      cyc(20);
      PS2_CLK = 1'b1;
      cyc(10);
    end
    PS2_DAT = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad_par);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    send_bits(bits, 11);
    cyc(10);
  endtask

  task automatic check_event(input string tag, input logic [9:0] exp);
    logic [9:0] got;
    got = (evq.size() > 0) ? evq.pop_front() : 10'h3FF;
    check(tag, {22'd0, got}, {22'd0, exp});
  endtask

  initial begin
    int p0, f0, o0, q0, w;

    cyc(3);
    check("reset_valid", {31'd0, ev_valid}, 32'd0);
    check("reset_count", {28'd0, fifo_count}, 32'd0);
    check("reset_head", {22'd0, ev_ext, ev_brk, ev_code}, 32'd0);
    check("reset_pulses", {29'd0, err_parity, err_frame, overflow}, 32'd0);
    reset_n = 1'b1;
    cyc(5);

    // Single good frame held in the FIFO
    send_byte(8'h1C, 1'b0);
    w = 0;
    while (!ev_valid && w < 100) begin
      cyc(1);
      w++;
    end
    check("first_valid", {31'd0, ev_valid}, 32'd1);
    check("first_head", {22'd0, ev_ext, ev_brk, ev_code}, 32'h01C);
    check("first_count", {28'd0, fifo_count}, 32'd1);
    check("first_noerr", n_par + n_frm + n_ovf, 32'd0);
    ev_ready = 1'b1;
    cyc(3);
    check_event("first_pop", 10'h01C);
    check("first_empty", {31'd0, ev_valid}, 32'd0);

    // Prefix folding: E0 F0 6B then plain 1C
    q0 = evq.size();
    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    cyc(5);
    check("prefix_no_event", evq.size(), q0);
    send_byte(8'h6B, 1'b0);
    cyc(5);
    check("prefix_one_event", evq.size(), q0 + 1);
    check_event("ext_brk_6b", 10'h36B);
    send_byte(8'h1C, 1'b0);
    cyc(5);
    check_event("flags_cleared", 10'h01C);

    // Parity error clears a pending E0
    p0 = n_par;
    f0 = n_frm;
    send_byte(8'hE0, 1'b0);
    send_byte(8'h1C, 1'b1);
    cyc(5);
    check("parity_pulse", n_par, p0 + 1);
    check("parity_no_event", evq.size(), 32'd0);
    send_byte(8'h12, 1'b0);
    cyc(5);
    check_event("after_parity", 10'h012);
    check("parity_no_frame", n_frm, f0);

    // Watchdog abort of a partial frame
    f0 = n_frm;
    send_bits(11'b000_0101_0110, 5);
    cyc(TIMEOUT_CYC + 20);
    check("timeout_pulse", n_frm, f0 + 1);
    send_byte(8'h29, 1'b0);
    cyc(5);
    check_event("after_timeout", 10'h029);
    check("timeout_single", n_frm, f0 + 1);

    // Fill past capacity with the consumer stalled
    ev_ready = 1'b0;
    o0 = n_ovf;
    for (int i = 0; i < 9; i++) send_byte(8'h15 + 8'(i), 1'b0);
    cyc(5);
    check("full_count", {28'd0, fifo_count}, 32'd8);
    check("overflow_pulse", n_ovf, o0 + 1);
    check("full_head", {22'd0, ev_ext, ev_brk, ev_code}, 32'h015);
    ev_ready = 1'b1;
    cyc(20);
    check("drain_size", evq.size(), 32'd8);
    for (int i = 0; i < 8; i++) check_event("drain_order", {2'b00, 8'h15 + 8'(i)});
    check("drain_empty", {31'd0, ev_valid}, 32'd0);
    check("drain_count", {28'd0, fifo_count}, 32'd0);

    // Sub-threshold clock glitch in IDLE must be invisible
    p0 = n_par;
    f0 = n_frm;
    PS2_CLK = 1'b0;
    cyc(FILTER_LEN - 1);
    PS2_CLK = 1'b1;
    cyc(30);
    check("glitch_no_frame", n_frm, f0);
    check("glitch_no_event", evq.size(), 32'd0);

    // Reset mid-frame discards the partial frame
    send_bits(11'b000_0000_1100, 4);
    reset_n = 1'b0;
    cyc(1);
    reset_n = 1'b1;
    cyc(5);
    check("midreset_count", {28'd0, fifo_count}, 32'd0);
    send_byte(8'h5A, 1'b0);
    cyc(5);
    check("midreset_size", evq.size(), 32'd1);
    check_event("midreset_5a", 10'h05A);
    check("midreset_noerr", (n_frm - f0) + (n_par - p0), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
